spi_slave_stream: RTL

//  SPI slave with runtime-selectable mode and parametrised word width.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_slave_stream_if.sv | 25 ++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/spi_slave_stream.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, FSM state type and CPOL/CPHA accessors.
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_slave_stream_if.sv
// System-side valid/ready streams of the SPI slave: TX words in, RX words out.
interface spi_slave_stream_if
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and registered count/full/empty.
module sync_fifo
  import spi_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          full_reg;
  logic          empty_reg;
  logic          do_push;
  logic          do_pop;

  // Flags come from registers, so a pop never frees space for a push in the same cycle.
  assign do_push = push & ~full_reg;
  assign do_pop  = pop & ~empty_reg;

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == FULL_COUNT);
      empty_reg <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  assign pop_data = mem[rd_ptr_reg];
  assign count    = count_reg;
  assign full     = full_reg;
  assign empty    = empty_reg;

endmodule

// File: rtl/spi_slave_stream.sv
// SPI slave, all four modes, with TX/RX FIFOs toward on-chip logic.
// SPI pins are oversampled by clk through synchronisers; all logic runs on clk.
module spi_slave_stream
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               cfg_mode,
  spi_slave_stream_if.slave        stream,
  input  logic                     sclk,
  input  logic                     ss_n,
  input  logic                     mosi,
  output logic                     miso,
  output logic                     miso_oe,
  output logic                     busy,
  output logic                     tx_underrun,
  output logic                     rx_overrun
);

  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] ss_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic                   sclk_prev_reg;
  logic                   ss_prev_reg;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic                   lead_edge, trail_edge, sample_edge, shift_edge;

  state_t                 state_reg, state_next;
  logic [1:0]             mode_reg, mode_next;
  logic [DATA_W-1:0]      tx_shift_reg, tx_shift_next;
  logic [DATA_W-1:0]      rx_shift_reg, rx_shift_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   miso_reg, miso_next;
  logic                   first_reg, first_next;
  logic                   underrun_reg, underrun_next;
  logic                   overrun_reg, overrun_next;

  logic                   tx_pop, tx_full, tx_empty;
  logic [DATA_W-1:0]      tx_head, load_word;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic                   rx_push, rx_full, rx_empty;
  logic [DATA_W-1:0]      rx_word;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic                   unused_counts;

  sync_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (stream.tx_valid),
    .push_data (stream.tx_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  sync_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rx_push),
    .push_data (rx_word),
    .pop       (stream.rx_ready),
    .pop_data  (stream.rx_data),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign stream.tx_ready = ~tx_full;
  assign stream.rx_valid = ~rx_empty;
  assign unused_counts   = ^{tx_count, rx_count};

  // ss_n synchronisers idle high so reset looks like a deselected bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_reg <= '0;
      ss_sync_reg   <= '1;
      mosi_sync_reg <= '0;
      sclk_prev_reg <= 1'b0;
      ss_prev_reg   <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
      ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], ss_n};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
      sclk_prev_reg <= sclk_s;
      ss_prev_reg   <= ss_s;
    end
  end

  assign sclk_s      = sclk_sync_reg[SYNC_STAGES-1];
  assign ss_s        = ss_sync_reg[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_reg[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_prev_reg;
  assign sclk_fall   = ~sclk_s & sclk_prev_reg;
  assign ss_fall     = ~ss_s & ss_prev_reg;
  assign ss_rise     = ss_s & ~ss_prev_reg;
  assign lead_edge   = cpol(mode_reg) ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol(mode_reg) ? sclk_rise : sclk_fall;
  assign sample_edge = cpha(mode_reg) ? trail_edge : lead_edge;
  assign shift_edge  = cpha(mode_reg) ? lead_edge : trail_edge;
  assign load_word   = tx_empty ? '0 : tx_head;
  assign rx_word     = {rx_shift_reg[DATA_W-2:0], mosi_s};

  always_comb begin
    state_next    = state_reg;
    mode_next     = mode_reg;
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    cnt_next      = cnt_reg;
    miso_next     = miso_reg;
    first_next    = first_reg;
    underrun_next = 1'b0;
    overrun_next  = 1'b0;
    tx_pop        = 1'b0;
    rx_push       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ss_fall) begin
          state_next    = SHIFT;
          mode_next     = cfg_mode;
          cnt_next      = CNT_TOP;
          first_next    = 1'b1;
          rx_shift_next = '0;
          tx_pop        = 1'b1;
          underrun_next = tx_empty;
          tx_shift_next = load_word;
          if (!cpha(cfg_mode)) begin
            miso_next     = load_word[DATA_W-1];
            tx_shift_next = load_word << 1;
          end
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_next    = IDLE;
          cnt_next      = CNT_TOP;
          rx_shift_next = '0;
        end else begin
          if (sample_edge) begin
            rx_shift_next = rx_word;
            if (cnt_reg == '0) begin
              rx_push      = 1'b1;
              overrun_next = rx_full;
              cnt_next     = CNT_TOP;
            end else begin
              cnt_next = cnt_reg - 1'b1;
            end
          end
          // A shift edge after a completed word starts the next word without a gap.
          if (shift_edge) begin
            first_next = 1'b0;
            if (cnt_reg == CNT_TOP && !first_reg) begin
              tx_pop        = 1'b1;
              underrun_next = tx_empty;
              miso_next     = load_word[DATA_W-1];
              tx_shift_next = load_word << 1;
            end else begin
              miso_next     = tx_shift_reg[DATA_W-1];
              tx_shift_next = tx_shift_reg << 1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      mode_reg     <= SPI_MODE0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      cnt_reg      <= CNT_TOP;
      miso_reg     <= 1'b0;
      first_reg    <= 1'b0;
      underrun_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      tx_shift_reg <= tx_shift_next;
      rx_shift_reg <= rx_shift_next;
      cnt_reg      <= cnt_next;
      miso_reg     <= miso_next;
      first_reg    <= first_next;
      underrun_reg <= underrun_next;
      overrun_reg  <= overrun_next;
    end
  end

  assign miso        = miso_reg;
  assign miso_oe     = ~ss_s;
  assign busy        = (state_reg == SHIFT);
  assign tx_underrun = underrun_reg;
  assign rx_overrun  = overrun_reg;

endmodule
